// File: rtl/fp_control_unit.sv
// Sequencing FSM for the single-precision FP datapath: align, execute, normalise, round, done.
// Optional per-operation cycle counter enabled with the FP_CTRL_CYCLE_COUNT_EN macro.
module fp_control_unit #(
  parameter int EXP_W      = 8,
  parameter int FRAC_W     = 27,
  parameter int MAX_LSHIFT = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op_in,
  input  logic [EXP_W-1:0]  expDiff,
  input  logic [FRAC_W-1:0] fracResult,
  input  logic              carry,
  output logic [1:0]        operation,
  output logic              smallerExpSrc,
  output logic [EXP_W-1:0]  shiftRightQtt,
  output logic              alu,
  output logic              normalization_src,
  output logic              shift_src,
  output logic              shift,
  output logic              busy,
  output logic              done,
  output logic              invalid
`ifdef FP_CTRL_CYCLE_COUNT_EN
  ,
  output logic [5:0]        cycle_count
`endif
);

  localparam int CNT_W = $clog2(MAX_LSHIFT + 1);

  typedef enum logic [2:0] {IDLE, ALIGN, EXEC, NORM, ROUND, DONE} state_t;

  state_t            state, stateNxt;
  logic [CNT_W-1:0]  shiftCnt, shiftCntNxt;
  logic              reShifted, reShiftedNxt;
  logic              firstNormCarry, normDone, roundFix;

  logic [1:0]        operationNxt;
  logic              smallerExpSrcNxt, aluNxt, normSrcNxt, shiftSrcNxt, shiftNxt;
  logic              busyNxt, doneNxt, invalidNxt;
  logic [EXP_W-1:0]  shiftRightQttNxt;

  // shiftCnt stays 0 only on the first NORM cycle, since staying in NORM always increments it
  assign firstNormCarry = (shiftCnt == '0) && carry;
  assign normDone = firstNormCarry || (fracResult == '0) || fracResult[FRAC_W-1] ||
                    (shiftCnt == CNT_W'(MAX_LSHIFT));
  // A zero result is final; otherwise re-shift once on overflow or lost hidden bit
  assign roundFix = carry || (!fracResult[FRAC_W-1] && (fracResult != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      shiftCnt          <= '0;
      reShifted         <= 1'b0;
      operation         <= 2'b00;
      smallerExpSrc     <= 1'b0;
      shiftRightQtt     <= '0;
      alu               <= 1'b0;
      normalization_src <= 1'b1;
      shift_src         <= 1'b0;
      shift             <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      invalid           <= 1'b0;
    end else begin
      state             <= stateNxt;
      shiftCnt          <= shiftCntNxt;
      reShifted         <= reShiftedNxt;
      operation         <= operationNxt;
      smallerExpSrc     <= smallerExpSrcNxt;
      shiftRightQtt     <= shiftRightQttNxt;
      alu               <= aluNxt;
      normalization_src <= normSrcNxt;
      shift_src         <= shiftSrcNxt;
      shift             <= shiftNxt;
      busy              <= busyNxt;
      done              <= doneNxt;
      invalid           <= invalidNxt;
    end
  end

  always_comb begin
    stateNxt     = state;
    shiftCntNxt  = shiftCnt;
    reShiftedNxt = reShifted;
    case (state)
      IDLE: begin
        if (start) begin
          shiftCntNxt  = '0;
          reShiftedNxt = 1'b0;
          stateNxt     = (op_in == 2'b11) ? DONE : ALIGN;
        end
      end
      ALIGN: stateNxt = EXEC;
      EXEC:  stateNxt = NORM;
      NORM: begin
        if (normDone) stateNxt = ROUND;
        else          shiftCntNxt = shiftCnt + 1'b1;
      end
      ROUND: begin
        if (!reShifted && roundFix) reShiftedNxt = 1'b1;
        else                        stateNxt = DONE;
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, so they change together with the state
  always_comb begin
    operationNxt     = operation;
    smallerExpSrcNxt = smallerExpSrc;
    shiftRightQttNxt = shiftRightQtt;
    aluNxt           = 1'b0;
    normSrcNxt       = 1'b1;
    shiftSrcNxt      = 1'b0;
    shiftNxt         = 1'b0;
    busyNxt          = (stateNxt != IDLE);
    doneNxt          = (stateNxt == DONE);
    invalidNxt       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          operationNxt = op_in;
          invalidNxt   = (op_in == 2'b11);
        end
      end
      ALIGN: begin
        aluNxt = 1'b1;
        if (operation == 2'b10) begin
          smallerExpSrcNxt = 1'b1;
          shiftRightQttNxt = '0;
        end else if (!expDiff[EXP_W-1]) begin
          smallerExpSrcNxt = 1'b1;
          shiftRightQttNxt = expDiff;
        end else begin
          smallerExpSrcNxt = 1'b0;
          shiftRightQttNxt = -expDiff;
        end
      end
      NORM: begin
        normSrcNxt = 1'b0;
        if (firstNormCarry) begin
          shiftNxt    = 1'b1;
          shiftSrcNxt = 1'b1;
        end else if (!normDone) begin
          shiftNxt    = 1'b1;
        end
      end
      ROUND: begin
        normSrcNxt = 1'b0;
        if (stateNxt == ROUND) begin
          shiftNxt    = 1'b1;
          shiftSrcNxt = 1'b1;
        end
      end
      DONE:    normSrcNxt = 1'b1;
      default: normSrcNxt = 1'b1;
    endcase
  end

`ifdef FP_CTRL_CYCLE_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   cycle_count <= '0;
    else if (state == IDLE && start)             cycle_count <= '0;
    else if (busy && cycle_count != 6'd63)       cycle_count <= cycle_count + 6'd1;
  end
`endif

endmodule
